// File: rtl/midi_cc_rx.sv
// MIDI Control Change receiver: UART deserialiser plus CC parser, 75 MHz domain.
// Define MIDI_CHANNEL_FILTER_EN to accept Control Change only on channel CHANNEL.
module midi_cc_rx #(
    parameter int CLKS_PER_BIT = 2400,
    parameter int CHANNEL      = 0
) (
    input  logic       clk75MHz,
    input  logic       rst,
    input  logic       MIDI_RX,
    output logic [7:0] CTRLNUM,
    output logic [6:0] VALUE,
    output logic       CC_VALID,
    output logic       FRAME_ERR
);

    localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TW-1:0] FULL_RELOAD = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] HALF_RELOAD = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [3:0]    CH          = CHANNEL[3:0];

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    // Synchroniser and edge history are left unreset so that a line held low
    // across reset release never looks like a fresh start edge.
    logic sync1_q, rx_s_q, rx_prev_q;
    always_ff @(posedge clk75MHz) begin
        sync1_q   <= MIDI_RX;
        rx_s_q    <= sync1_q;
        rx_prev_q <= rx_s_q;
    end

    logic rx_fall;
    assign rx_fall = rx_prev_q & ~rx_s_q;

    state_t          state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [7:0]      shift_q, shift_d;
    logic            err_wait_q, err_wait_d;
    logic            smp_done_q, smp_done_d;
    logic            smp_bit_q, smp_bit_d;
    logic            byte_stb_q, byte_stb_d;
    logic            frame_err_q, frame_err_d;

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        err_wait_d = err_wait_q;
        smp_done_d = 1'b0;
        smp_bit_d  = smp_bit_q;
        case (state_q)
            IDLE: begin
                if (rx_fall) begin
                    state_d = START;
                    timer_d = HALF_RELOAD;
                end
            end
            START: begin
                if (timer_q == '0) begin
                    if (!rx_s_q) begin
                        state_d   = DATA;
                        timer_d   = FULL_RELOAD;
                        bit_idx_d = 3'd0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            DATA: begin
                if (timer_q == '0) begin
                    shift_d = {rx_s_q, shift_q[7:1]};
                    timer_d = FULL_RELOAD;
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            STOP: begin
                if (err_wait_q) begin
                    if (rx_s_q) begin
                        state_d    = IDLE;
                        err_wait_d = 1'b0;
                    end
                end else if (timer_q == '0) begin
                    smp_done_d = 1'b1;
                    smp_bit_d  = rx_s_q;
                    if (rx_s_q) begin
                        state_d = IDLE;
                    end else begin
                        err_wait_d = 1'b1;
                    end
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        // The stop sample is registered first, so strobes land one cycle after it.
        byte_stb_d  = smp_done_q & smp_bit_q;
        frame_err_d = smp_done_q & ~smp_bit_q;
    end

    logic is_cc_status;
`ifdef MIDI_CHANNEL_FILTER_EN
    assign is_cc_status = (shift_q == {4'hB, CH});
`else
    logic unused_channel;
    assign unused_channel = ^CH;
    assign is_cc_status   = (shift_q[7:4] == 4'hB);
`endif

    logic       cc_active_q, cc_active_d;
    logic       need_d2_q, need_d2_d;
    logic [6:0] ctrl_tmp_q, ctrl_tmp_d;
    logic [7:0] ctrlnum_q, ctrlnum_d;
    logic [6:0] value_q, value_d;
    logic       cc_valid_q, cc_valid_d;

    always_comb begin
        cc_active_d = cc_active_q;
        need_d2_d   = need_d2_q;
        ctrl_tmp_d  = ctrl_tmp_q;
        ctrlnum_d   = ctrlnum_q;
        value_d     = value_q;
        cc_valid_d  = 1'b0;
        if (byte_stb_q) begin
            if (shift_q >= 8'hF8) begin
                cc_active_d = cc_active_q;
            end else if (shift_q[7:4] == 4'hF) begin
                cc_active_d = 1'b0;
                need_d2_d   = 1'b0;
            end else if (shift_q[7]) begin
                cc_active_d = is_cc_status;
                need_d2_d   = 1'b0;
            end else if (cc_active_q) begin
                if (!need_d2_q) begin
                    ctrl_tmp_d = shift_q[6:0];
                    need_d2_d  = 1'b1;
                end else begin
                    ctrlnum_d  = {1'b0, ctrl_tmp_q};
                    value_d    = shift_q[6:0];
                    cc_valid_d = 1'b1;
                    need_d2_d  = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk75MHz) begin
        if (rst) begin
            state_q     <= IDLE;
            timer_q     <= '0;
            bit_idx_q   <= 3'd0;
            shift_q     <= 8'h00;
            err_wait_q  <= 1'b0;
            smp_done_q  <= 1'b0;
            smp_bit_q   <= 1'b0;
            byte_stb_q  <= 1'b0;
            frame_err_q <= 1'b0;
            cc_active_q <= 1'b0;
            need_d2_q   <= 1'b0;
            ctrl_tmp_q  <= 7'h00;
            ctrlnum_q   <= 8'h00;
            value_q     <= 7'h00;
            cc_valid_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            err_wait_q  <= err_wait_d;
            smp_done_q  <= smp_done_d;
            smp_bit_q   <= smp_bit_d;
            byte_stb_q  <= byte_stb_d;
            frame_err_q <= frame_err_d;
            cc_active_q <= cc_active_d;
            need_d2_q   <= need_d2_d;
            ctrl_tmp_q  <= ctrl_tmp_d;
            ctrlnum_q   <= ctrlnum_d;
            value_q     <= value_d;
            cc_valid_q  <= cc_valid_d;
        end
    end

    assign CTRLNUM   = ctrlnum_q;
    assign VALUE     = value_q;
    assign CC_VALID  = cc_valid_q;
    assign FRAME_ERR = frame_err_q;

endmodule

// File: tb/tb_midi_cc_rx.sv
// Self-checking bench for midi_cc_rx: directed MIDI byte streams, expected CC pairs queued.
module tb_midi_cc_rx;

    localparam int CPB = 16;
    // Start-drive to CC_VALID: 2 sync stages + IDLE->START, half bit,
    // 9 full bits to the stop sample, then 2 cycles to CC_VALID.
    localparam int LAT = 3 + CPB / 2 + 9 * CPB + 2;

    logic       clk75MHz = 1'b0;
    logic       rst = 1'b1;
    logic       MIDI_RX = 1'b1;
    logic [7:0] CTRLNUM;
    logic [6:0] VALUE;
    logic       CC_VALID;
    logic       FRAME_ERR;

    midi_cc_rx #(.CLKS_PER_BIT(CPB), .CHANNEL(3)) dut (
        .clk75MHz (clk75MHz),
        .rst      (rst),
        .MIDI_RX  (MIDI_RX),
        .CTRLNUM  (CTRLNUM),
        .VALUE    (VALUE),
        .CC_VALID (CC_VALID),
        .FRAME_ERR(FRAME_ERR)
    );

    always #5 clk75MHz = ~clk75MHz;

    int cyc = 0;
    always @(posedge clk75MHz) cyc = cyc + 1;

    int checks = 0;
    int passes = 0;
    int fe_count = 0;
    int last_cc_cyc = 0;
    int t_last_start = 0;
    logic prev_cc = 1'b0;
    logic [13:0] exp_q[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic exp_cc(input logic [6:0] c, input logic [6:0] v);
        exp_q.push_back({c, v});
    endtask

    // Monitor: pops the scoreboard on every CC_VALID pulse.
    always @(negedge clk75MHz) begin
        logic [13:0] e;
        if (!rst) begin
            if (CC_VALID) begin
                chk("cc_valid_width", int'(prev_cc), 0);
                last_cc_cyc = cyc;
                if (exp_q.size() == 0) begin
                    checks++;
                    $display("FAIL cc_unexpected: got ctrl 0x%0h val 0x%0h, expected no pulse",
                             CTRLNUM, VALUE);
                end else begin
                    e = exp_q.pop_front();
                    chk("cc_ctrlnum", int'(CTRLNUM), int'({1'b0, e[13:7]}));
                    chk("cc_value", int'(VALUE), int'(e[6:0]));
                end
            end
            if (FRAME_ERR) fe_count++;
        end
        prev_cc = CC_VALID;
    end

    // Every driver task starts and ends on a negedge.
    task automatic drive_bit(input logic lvl);
        MIDI_RX = lvl;
        repeat (CPB) @(negedge clk75MHz);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_lvl = 1'b1,
                             input int abort_bit = -1);
        t_last_start = cyc;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) begin
            if (i == abort_bit) begin
                MIDI_RX = b[i];
                repeat (CPB / 2) @(negedge clk75MHz);
                rst = 1'b1;
                repeat (2) @(negedge clk75MHz);
                rst = 1'b0;
                repeat (CPB - CPB / 2 - 2) @(negedge clk75MHz);
            end else begin
                drive_bit(b[i]);
            end
        end
        drive_bit(stop_lvl);
        if (!stop_lvl) drive_bit(1'b1);
    endtask

    task automatic idle(input int bits);
        MIDI_RX = 1'b1;
        repeat (bits * CPB) @(negedge clk75MHz);
    endtask

    task automatic drain(input string name);
        idle(2);
        chk(name, exp_q.size(), 0);
    endtask

    initial begin
        @(negedge clk75MHz);
        repeat (5) @(negedge clk75MHz);
        rst = 1'b0;
        @(negedge clk75MHz);
        chk("reset_ctrlnum", int'(CTRLNUM), 0);
        chk("reset_value", int'(VALUE), 0);
        chk("reset_cc_valid", int'(CC_VALID), 0);
        chk("reset_frame_err", int'(FRAME_ERR), 0);
        idle(2);

        // Basic CC with latency measured on the third byte
        exp_cc(7'h07, 7'h64);
        send_byte(8'hB0);
        send_byte(8'h07);
        send_byte(8'h64);
        drain("drain_basic");
        chk("cc_latency", last_cc_cyc - t_last_start, LAT);

        // Running status, back-to-back bytes
        exp_cc(7'h10, 7'h7F);
        exp_cc(7'h11, 7'h00);
        send_byte(8'hB0);
        send_byte(8'h10);
        send_byte(8'h7F);
        send_byte(8'h11);
        send_byte(8'h00);
        drain("drain_running");

        // Real-time bytes interleaved, then a Note On that must not update
        exp_cc(7'h05, 7'h20);
        send_byte(8'hB0);
        send_byte(8'hF8);
        send_byte(8'h05);
        send_byte(8'hFE);
        send_byte(8'h20);
        drain("drain_realtime");
        send_byte(8'h90);
        send_byte(8'h3C);
        send_byte(8'h40);
        drain("drain_noteon");
        chk("hold_ctrlnum", int'(CTRLNUM), 8'h05);
        chk("hold_value", int'(VALUE), 7'h20);

        // Framing error, then recovery
        send_byte(8'h07, 1'b0);
        idle(2);
        chk("frame_err_count", fe_count, 1);
        exp_cc(7'h01, 7'h02);
        send_byte(8'hB0);
        send_byte(8'h01);
        send_byte(8'h02);
        drain("drain_after_ferr");

        // Reset during bit 4 of the value byte
        send_byte(8'hB0);
        send_byte(8'h0A);
        send_byte(8'h40, 1'b1, 4);
        chk("midreset_ctrlnum", int'(CTRLNUM), 0);
        chk("midreset_value", int'(VALUE), 0);
        idle(12);
        chk("midreset_ctrlnum_settled", int'(CTRLNUM), 0);
        exp_cc(7'h0A, 7'h40);
        send_byte(8'hB0);
        send_byte(8'h0A);
        send_byte(8'h40);
        drain("drain_after_reset");

        // Channel handling for status 0xB5 / 0xB3
`ifdef MIDI_CHANNEL_FILTER_EN
        send_byte(8'hB5);
        send_byte(8'h01);
        send_byte(8'h02);
        drain("drain_filter_reject");
        chk("filter_hold_ctrlnum", int'(CTRLNUM), 8'h0A);
        exp_cc(7'h01, 7'h02);
        send_byte(8'hB3);
        send_byte(8'h01);
        send_byte(8'h02);
        drain("drain_filter_accept");
`else
        exp_cc(7'h01, 7'h02);
        send_byte(8'hB5);
        send_byte(8'h01);
        send_byte(8'h02);
        drain("drain_any_channel");
`endif

        idle(2);
        chk("final_queue_empty", exp_q.size(), 0);
        chk("final_frame_err_count", fe_count, 1);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
